sram_ctrl: RTL and testbench
============================

# sram_ctrl

Synchronous controller sitting directly upstream of the 64×5 asynchronous SRAM (active-low CE/OE/WE, shared bidirectional data bus). It accepts single-word read/write requests over a valid/ready handshake and generates glitch-free, registered SRAM strobes with fixed setup, pulse and hold timing. It owns the tri-state data bus, and returns read data with a one-cycle response pulse.

## Interface
- ADDR_W, 6, SRAM address width
- DATA_W, 5, SRAM data width
- RD_WAIT, 2, cycles CE/OE held low before read sample (≥1)
- WR_PULSE, 2, cycles WE held low (≥1)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; combinational = (state==IDLE) && !rst
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  target address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle pulse; rsp_rdata valid
- rsp_rdata  out  DATA_W  read data, held until next read completes
- sram_addr  out  ADDR_W  to SRAM addr
- sram_data  inout  DATA_W  to SRAM data bus
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active low
- busy  out  1  state != IDLE

## Operation
- States: IDLE, RD_ACT, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE: all strobes 1, bus released. On req_valid && req_ready: latch addr/we/wdata into registers; go to RD_ACT (read) or WR_SETUP (write).
- RD_ACT: ce_n=0, oe_n=0, we_n=1, sram_addr=latched addr, bus released; wait counter runs RD_WAIT cycles; on final cycle rsp_rdata <= sram_data; next RD_DONE.
- RD_DONE: strobes 1, rsp_valid=1 for this cycle; next IDLE.
- WR_SETUP (1 cycle): ce_n=0, oe_n=1, we_n=1, bus driven with latched wdata.
- WR_PULSE (WR_PULSE cycles): ce_n=0, we_n=0, bus driven.
- WR_HOLD (1 cycle): ce_n=0, we_n=1, bus still driven; next IDLE. No response for writes.
- Bus drive enable asserted only in WR_SETUP/WR_PULSE/WR_HOLD; oe_n is never 0 in any cycle where drive is enabled.
- Strobes, sram_addr and drive enable are all flops (no combinational decode to pins).
- Requests arriving while busy are not accepted (ready=0); requester holds them.

## Timing
- Reset values: sram_ce_n=sram_oe_n=sram_we_n=1, sram_addr=0, sram_data=Z, rsp_valid=0, rsp_rdata=0, busy=0, state=IDLE.
- Read accepted at edge N: strobes low from N+1 through N+RD_WAIT; sample at edge N+RD_WAIT+1; rsp_valid high cycle N+RD_WAIT+1; ready again cycle N+RD_WAIT+2.
- Write accepted at edge N: WE low cycles N+2..N+1+WR_PULSE; ready again after WR_PULSE+3 cycles total.
- Bus turnaround: at least one cycle (RD_DONE/IDLE) with oe_n=1 and bus released between any read and a following write.
- Address and data stable for the whole CE-low window; sram_addr keeps last value in IDLE.
- rst mid-operation: next edge forces IDLE, strobes 1, bus Z, rsp_valid 0; aborted read produces no response; in-flight write may be partial (accepted).
- rst and req_valid same cycle: request not accepted.

## Structure
- Package sram_pkg: state enum, ADDR_W/DATA_W defaults, RD_WAIT/WR_PULSE defaults.
- Wait counter width = clog2(max(RD_WAIT, WR_PULSE))+1, shared by read and write states.
- One natural sub-module: sram_io_buf (registered drive enable + tri-state buffer for sram_data).

## Test plan
- Write addr 6'h05 data 5'h1A, then read 6'h05 → rsp_valid once, rsp_rdata=5'h1A at cycle N+3 (RD_WAIT=2).
- Write all 64 addresses with data=addr[4:0]^5'h15, read back all → every word matches; addr 6'h3F wraps correctly.
- Read followed immediately by write (req_valid held) → bus Z and oe_n=1 for ≥1 cycle before drive; no cycle with oe_n=0 and drive enabled.
- req_valid held during write → ready=0 for WR_PULSE+3 cycles, second request accepted exactly once.
- Assert rst during RD_ACT → strobes 1 next cycle, no rsp_valid, ready=1 after rst drops.
- WE pulse width check with WR_PULSE=3 → we_n low exactly 3 cycles, ce_n low 5 cycles, data stable throughout.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and default geometry/timing for the asynchronous SRAM controller.
package sram_pkg;

  localparam int unsigned ADDR_W_DEF   = 6;
  localparam int unsigned DATA_W_DEF   = 5;
  localparam int unsigned RD_WAIT_DEF  = 2;
  localparam int unsigned WR_PULSE_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ACT,
    ST_RD_DONE,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Request/response handshake between a requester and the SRAM controller.
interface sram_ctrl_if
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );

endinterface

// File: rtl/sram_io_buf.sv
// Registered drive enable and tri-state buffer for the shared SRAM data bus.
module sram_io_buf #(
  parameter int unsigned DATA_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              drive_d,
  input  logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] din,
  inout  wire  [DATA_W-1:0] pad
);

  logic drive_q;

  always_ff @(posedge clk) begin
    if (rst) drive_q <= 1'b0;
    else     drive_q <= drive_d;
  end

  assign pad = drive_q ? dout : 'z;
  assign din = pad;

endmodule

// File: rtl/sram_ctrl.sv
// Single-word read/write controller for an asynchronous SRAM with registered strobes.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned RD_WAIT  = RD_WAIT_DEF,
  parameter int unsigned WR_PULSE = WR_PULSE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  sram_ctrl_if.slave        bus,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int unsigned CNT_W = $clog2(max_u(RD_WAIT, WR_PULSE)) + 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_PULSE - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              drive_d;
  logic [DATA_W-1:0] sram_din;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = RD_LOAD;
          state_d = bus.req_we ? ST_WR_SETUP : ST_RD_ACT;
        end
      end
      ST_RD_ACT: begin
        if (cnt_q == '0) begin
          rdata_d = sram_din;
          state_d = ST_RD_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RD_DONE:  state_d = ST_IDLE;
      ST_WR_SETUP: begin
        cnt_d   = WR_LOAD;
        state_d = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        if (cnt_q == '0) state_d = ST_WR_HOLD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_WR_HOLD:  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    // Pin-level strobes are decoded from the next state so the flops present
    // the current state's levels without any combinational path to the pins.
    ce_n_d      = (state_d == ST_IDLE) || (state_d == ST_RD_DONE);
    oe_n_d      = (state_d != ST_RD_ACT);
    we_n_d      = (state_d != ST_WR_PULSE);
    drive_d     = state_d inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD};
    rsp_valid_d = (state_d == ST_RD_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
    end
  end

  sram_io_buf #(.DATA_W(DATA_W)) u_io_buf (
    .clk     (clk),
    .rst     (rst),
    .drive_d (drive_d),
    .dout    (wdata_q),
    .din     (sram_din),
    .pad     (sram_data)
  );

  assign bus.req_ready = (state_q == ST_IDLE) && !rst;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign sram_addr     = addr_q;
  assign sram_ce_n     = ce_n_q;
  assign sram_oe_n     = oe_n_q;
  assign sram_we_n     = we_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: SRAM model, read scoreboard, vector table and timing sequences.
module tb_sram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_ctrl_if #(.ADDR_W(6), .DATA_W(5)) bus ();
  sram_ctrl_if #(.ADDR_W(6), .DATA_W(5)) bus3 ();

  logic [5:0] sram_addr, sram_addr3;
  wire  [4:0] sram_data, sram_data3;
  logic ce_n, oe_n, we_n, ce3_n, oe3_n, we3_n;

  sram_ctrl #(.ADDR_W(6), .DATA_W(5), .RD_WAIT(2), .WR_PULSE(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n)
  );

  sram_ctrl #(.ADDR_W(6), .DATA_W(5), .RD_WAIT(2), .WR_PULSE(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .sram_addr(sram_addr3), .sram_data(sram_data3),
    .sram_ce_n(ce3_n), .sram_oe_n(oe3_n), .sram_we_n(we3_n)
  );

  // Asynchronous SRAM model: drives on CE&OE, captures while WE is low.
  logic [4:0] mem [64];
  assign sram_data = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : 'z;
  always @(posedge clk) if (!ce_n && !we_n) mem[sram_addr] <= sram_data;

  typedef struct {
    logic       we;
    logic [5:0] addr;
    logic [4:0] wdata;
    logic [4:0] exp;
  } vec_t;

  vec_t       vecs [8];
  logic [4:0] exp_q [$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [5:0] cur_addr  = '0;
  logic [4:0] cur_wdata = '0;
  logic       prev_oe_low = 1'b0;
  bit         mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Latch what the controller should be presenting for the accepted request.
  always @(posedge clk) begin
    if (bus.req_valid && bus.req_ready) begin
      cur_addr <= bus.req_addr;
      if (bus.req_we) cur_wdata <= bus.req_wdata;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 0, 1);
        else chk("rsp_rdata", int'(bus.rsp_rdata), int'(exp_q.pop_front()));
      end
      chk("oe_we_overlap", int'(oe_n | we_n), 1);
      chk("turnaround", int'(!(prev_oe_low && oe_n && !ce_n)), 1);
      if (!ce_n) chk("addr_stable", int'(sram_addr), int'(cur_addr));
      if (!ce_n && oe_n) chk("wdata_stable", int'(sram_data), int'(cur_wdata));
      prev_oe_low = !oe_n;
    end
  end

  task automatic issue(input logic we, input logic [5:0] a, input logic [4:0] d,
                       input logic [4:0] e, input bit push);
    int unsigned w = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (!bus.req_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", int'(bus.req_ready), 1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (!we && push) exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned w = 0;
    while ((exp_q.size() != 0 || bus.busy) && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    int we_low, ce_low;
    logic [4:0] last_exp;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_addr = '0; bus3.req_wdata = '0;

    vecs[0] = '{1'b1, 6'h05, 5'h1A, 5'h00};
    vecs[1] = '{1'b0, 6'h05, 5'h00, 5'h1A};
    vecs[2] = '{1'b1, 6'h3F, 5'h07, 5'h00};
    vecs[3] = '{1'b1, 6'h00, 5'h1F, 5'h00};
    vecs[4] = '{1'b0, 6'h3F, 5'h00, 5'h07};
    vecs[5] = '{1'b0, 6'h00, 5'h00, 5'h1F};
    vecs[6] = '{1'b1, 6'h05, 5'h0C, 5'h00};
    vecs[7] = '{1'b0, 6'h05, 5'h00, 5'h0C};

    // Reset state, with a request pending to confirm it is not accepted.
    repeat (2) @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 6'h09; bus.req_wdata = 5'h1E;
    @(negedge clk);
    chk("rst_ce_n", int'(ce_n), 1);
    chk("rst_oe_n", int'(oe_n), 1);
    chk("rst_we_n", int'(we_n), 1);
    chk("rst_addr", int'(sram_addr), 0);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_rsp_rdata", int'(bus.rsp_rdata), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_ready", int'(bus.req_ready), 0);
    chk("rst_ce3_n", int'(ce3_n), 1);
    rst = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", int'(bus.req_ready), 1);
    chk("post_rst_busy", int'(bus.busy), 0);
    mon_en = 1'b1;

    // Read latency: accepted at edge N, response in cycle N+3, ready at N+4.
    issue(1'b1, 6'h05, 5'h1A, 5'h00, 1'b0);
    idle();
    drain();
    issue(1'b0, 6'h05, 5'h00, 5'h1A, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid = 1'b0;
      chk($sformatf("rd_ce_n_k%0d", k), int'(ce_n), (k <= 2) ? 0 : 1);
      chk($sformatf("rd_oe_n_k%0d", k), int'(oe_n), (k <= 2) ? 0 : 1);
      chk($sformatf("rd_rsp_valid_k%0d", k), int'(bus.rsp_valid), (k == 3) ? 1 : 0);
      chk($sformatf("rd_ready_k%0d", k), int'(bus.req_ready), (k == 4) ? 1 : 0);
    end
    @(negedge clk);
    chk("rdata_hold", int'(bus.rsp_rdata), 5'h1A);

    for (int i = 0; i < 8; i++) issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, 1'b1);
    idle();
    drain();

    // Every address with a distinct pattern, then read all back.
    for (int i = 0; i < 64; i++) begin
      logic [5:0] a;
      a = 6'(i);
      issue(1'b1, a, a[4:0] ^ 5'h15, 5'h00, 1'b0);
    end
    for (int i = 0; i < 64; i++) begin
      logic [5:0] a;
      a = 6'(i);
      issue(1'b0, a, 5'h00, a[4:0] ^ 5'h15, 1'b1);
    end
    idle();
    drain();

    // Write with a read held pending: ready returns at N+5, read taken once.
    issue(1'b1, 6'h11, 5'h09, 5'h00, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.req_we = 1'b0; bus.req_addr = 6'h11; bus.req_wdata = 5'h00;
      end
      chk($sformatf("wr_ready_k%0d", k), int'(bus.req_ready), (k == 5) ? 1 : 0);
      chk($sformatf("wr_we_n_k%0d", k), int'(we_n), (k == 2 || k == 3) ? 0 : 1);
      chk($sformatf("wr_ce_n_k%0d", k), int'(ce_n), (k <= 4) ? 0 : 1);
    end
    @(posedge clk);
    exp_q.push_back(5'h09);
    idle();
    chk("held_rd_busy", int'(bus.busy), 1);
    drain();

    // Read immediately followed by a held write: two strobe-idle cycles between.
    issue(1'b0, 6'h11, 5'h00, 5'h09, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.req_we = 1'b1; bus.req_addr = 6'h12; bus.req_wdata = 5'h05;
      end
      if (k == 5) bus.req_valid = 1'b0;
      chk($sformatf("rw_ce_n_k%0d", k), int'(ce_n), (k == 3 || k == 4) ? 1 : 0);
      chk($sformatf("rw_oe_n_k%0d", k), int'(oe_n), (k <= 2) ? 0 : 1);
    end
    drain();
    issue(1'b0, 6'h12, 5'h00, 5'h05, 1'b1);
    idle();
    drain();

    // Reset during RD_ACT: abort without a response.
    issue(1'b0, 6'h05, 5'h00, 5'h00, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ce_n", int'(ce_n), 1);
    chk("abort_oe_n", int'(oe_n), 1);
    chk("abort_we_n", int'(we_n), 1);
    chk("abort_rsp_valid", int'(bus.rsp_valid), 0);
    chk("abort_ready_in_rst", int'(bus.req_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", int'(bus.req_ready), 1);
    chk("abort_busy", int'(bus.busy), 0);
    repeat (4) @(negedge clk);

    // Reset and request together: the write must not land.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 6'h05; bus.req_wdata = 5'h03;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 1'b0;
    chk("rst_req_busy", int'(bus.busy), 0);
    issue(1'b0, 6'h05, 5'h00, 5'h05 ^ 5'h15, 1'b1);
    idle();
    drain();

    // WR_PULSE=3 instance: 3 WE-low cycles inside a 5-cycle CE window.
    @(negedge clk);
    bus3.req_valid = 1'b1; bus3.req_we = 1'b1; bus3.req_addr = 6'h2A; bus3.req_wdata = 5'h0B;
    for (int w = 0; w < 40 && !bus3.req_ready; w++) @(negedge clk);
    chk("p3_ready", int'(bus3.req_ready), 1);
    @(posedge clk);
    we_low = 0;
    ce_low = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) bus3.req_valid = 1'b0;
      if (!we3_n) we_low++;
      if (!ce3_n) ce_low++;
      chk($sformatf("p3_we_n_k%0d", k), int'(we3_n), (k >= 2 && k <= 4) ? 0 : 1);
      chk($sformatf("p3_ce_n_k%0d", k), int'(ce3_n), (k <= 5) ? 0 : 1);
      chk($sformatf("p3_oe_n_k%0d", k), int'(oe3_n), 1);
      if (k <= 5) begin
        chk($sformatf("p3_data_k%0d", k), int'(sram_data3), 5'h0B);
        chk($sformatf("p3_addr_k%0d", k), int'(sram_addr3), 6'h2A);
      end
    end
    chk("p3_we_width", we_low, 3);
    chk("p3_ce_width", ce_low, 5);
    last_exp = 5'h05 ^ 5'h15;
    chk("final_rdata_hold", int'(bus.rsp_rdata), int'(last_exp));

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
